// File: rtl/bp_fe_bht_update_queue.sv
// bp_fe_bht_update_queue: FIFO of resolved-branch updates draining one per cycle into the BHT write port.
// Optional same-cycle bypass when empty is enabled by defining BP_FE_BHT_UPDQ_BYPASS_EN.
module bp_fe_bht_update_queue #(
   parameter int bht_idx_width_p = 9,
   parameter int els_p           = 4,
   localparam int ptr_w          = $clog2(els_p),
   localparam int cnt_w          = $clog2(els_p + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       upd_v_i,
   input  logic [bht_idx_width_p-1:0] upd_idx_i,
   input  logic                       upd_taken_i,
   output logic                       upd_ready_o,
   input  logic                       stall_i,
   input  logic                       flush_i,
   output logic                       w_v_o,
   output logic [bht_idx_width_p-1:0] idx_w_o,
   output logic                       correct_o,
   output logic [cnt_w-1:0]           count_o
);
   logic [bht_idx_width_p-1:0] idx_q [els_p];
   logic                       taken_q [els_p];
   logic [ptr_w-1:0]           head_q, head_d, tail_q, tail_d;
   logic [cnt_w-1:0]           count_q, count_d;
   logic                       empty, full, enq, deq, byp;
   // handshake, write-port drive and next-state pointers/occupancy
   always_comb begin
      empty       = count_q == '0;
      full        = count_q == cnt_w'(els_p);
      upd_ready_o = reset_n_i & ~full & ~flush_i;
      deq         = ~empty & ~stall_i & ~flush_i;
`ifdef BP_FE_BHT_UPDQ_BYPASS_EN
      byp         = reset_n_i & empty & ~stall_i & ~flush_i & upd_v_i;
      w_v_o       = deq | byp;
      idx_w_o     = byp ? upd_idx_i : idx_q[head_q];
      correct_o   = byp ? upd_taken_i : taken_q[head_q];
`else
      byp         = 1'b0;
      w_v_o       = deq;
      idx_w_o     = idx_q[head_q];
      correct_o   = taken_q[head_q];
`endif
      enq         = upd_v_i & upd_ready_o & ~byp;
      head_d      = flush_i ? '0 : (deq ? head_q + ptr_w'(1) : head_q);
      tail_d      = flush_i ? '0 : (enq ? tail_q + ptr_w'(1) : tail_q);
      count_d     = flush_i ? '0 : count_q + cnt_w'(enq) - cnt_w'(deq);
      count_o     = count_q;
   end
   // pointer/occupancy state and entry storage; reset clears everything so outputs never show X
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < els_p; i++) begin
            idx_q[i]   <= '0;
            taken_q[i] <= 1'b0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (enq) begin
            idx_q[tail_q]   <= upd_idx_i;
            taken_q[tail_q] <= upd_taken_i;
         end
      end
   end
endmodule
